dmem_arbiter: RTL

//  Shares the single-port data memory between the CPU load/store path (port C) and the

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: fixed priority to port C with a
// starvation limit for port D, sub-word load extraction and read-modify-write byte/half stores.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wdata,
    input  logic [3:0]        c_sltype,
    output logic              c_ack,
    output logic [31:0]       c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_sltype,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e            state_q;
    logic              owner_q;
    logic [3:0]        starve_q;
    logic              c_ack_q, d_ack_q, c_err_q, d_err_q, mem_we_q;
    logic [31:0]       c_rdata_q, d_rdata_q, mem_wd_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              pick_dport, pick_cport, g_legal;
    logic [ADDR_W-1:0] g_word;
    logic [1:0]        g_off, o_off;
    logic [31:0]       g_wdata, lane, load_d, merge_d, lane_mask;
    logic [3:0]        g_type, o_type;
    logic [15:0]       o_wdata;
    logic [4:0]        o_shift;
    logic              unused_addr_bits;

    function automatic logic legal(input logic [3:0] t, input logic [1:0] a);
        case (t)
            4'b0000, 4'b0100, 4'b1000: legal = 1'b1;
            4'b0001, 4'b0101, 4'b1001: legal = ~a[0];
            4'b0010, 4'b1010:          legal = (a == 2'b00);
            default:                   legal = 1'b0;
        endcase
    endfunction

    // Arbitration looks at the live requests; once granted, the owner's inputs are used directly.
    assign pick_dport = d_req & (~c_req | (starve_q == STARVE_LIM));
    assign pick_cport = c_req & ~pick_dport;
    assign g_word     = pick_dport ? d_addr[ADDR_W+1:2] : c_addr[ADDR_W+1:2];
    assign g_off      = pick_dport ? d_addr[1:0] : c_addr[1:0];
    assign g_wdata    = pick_dport ? d_wdata : c_wdata;
    assign g_type     = pick_dport ? d_sltype : c_sltype;
    assign g_legal    = legal(g_type, g_off);

    assign o_off      = owner_q ? d_addr[1:0] : c_addr[1:0];
    assign o_type     = owner_q ? d_sltype : c_sltype;
    assign o_wdata    = owner_q ? d_wdata[15:0] : c_wdata[15:0];
    assign o_shift    = {o_off, 3'b000};
    assign lane       = mem_rd >> o_shift;

    assign unused_addr_bits = ^{c_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

    always_comb begin
        load_d = lane;
        case (o_type)
            4'b0000: load_d = {{24{lane[7]}}, lane[7:0]};
            4'b0001: load_d = {{16{lane[15]}}, lane[15:0]};
            4'b0100: load_d = {24'b0, lane[7:0]};
            4'b0101: load_d = {16'b0, lane[15:0]};
            default: load_d = lane;
        endcase
    end

    // Little-endian lane replacement for sb/sh; untouched bytes come from the word just read.
    assign lane_mask = o_type[0] ? 32'h0000FFFF : 32'h000000FF;
    assign merge_d   = (mem_rd & ~(lane_mask << o_shift))
                     | (({16'b0, o_wdata} & lane_mask) << o_shift);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            starve_q   <= '0;
            c_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            c_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
            mem_wd_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            if (!d_req) starve_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_cport | pick_dport) begin
                        owner_q <= pick_dport;
                        if (pick_dport) begin
                            starve_q  <= '0;
                            d_rdata_q <= '0;
                        end else begin
                            c_rdata_q <= '0;
                            if (d_req && starve_q != STARVE_LIM) starve_q <= starve_q + 4'd1;
                        end
                        if (!g_legal) begin
                            state_q <= RESP;
                            c_ack_q <= ~pick_dport;
                            d_ack_q <= pick_dport;
                            c_err_q <= ~pick_dport;
                            d_err_q <= pick_dport;
                        end else begin
                            mem_addr_q <= g_word;
                            if (!g_type[3]) begin
                                state_q <= ACCESS;
                            end else if (g_type[1]) begin
                                mem_we_q <= 1'b1;
                                mem_wd_q <= g_wdata;
                                state_q  <= ACCESS;
                            end else begin
                                state_q <= RMW_RD;
                            end
                        end
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    if (!o_type[3]) begin
                        if (owner_q) d_rdata_q <= load_d;
                        else         c_rdata_q <= load_d;
                    end
                    c_ack_q <= ~owner_q;
                    d_ack_q <= owner_q;
                    state_q <= RESP;
                end
                RMW_RD: begin
                    mem_wd_q <= merge_d;
                    mem_we_q <= 1'b1;
                    state_q  <= RMW_WR;
                end
                RMW_WR: begin
                    mem_we_q <= 1'b0;
                    c_ack_q  <= ~owner_q;
                    d_ack_q  <= owner_q;
                    state_q  <= RESP;
                end
                RESP: begin
                    c_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    c_err_q <= 1'b0;
                    d_err_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c_ack    = c_ack_q;
    assign d_ack    = d_ack_q;
    assign c_err    = c_err_q;
    assign d_err    = d_err_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    // A write must never land on an edge where reset is asserted.
    assign mem_we   = mem_we_q & ~rst;

endmodule
